pcm_hamming_tx: RTL and testbench

Serial line-coding stage directly downstream of the PCM encoder. Accepts one 8-bit PCM code word per handshake, splits it into high and low nibbles, Hamming(7,4)-encodes each, and shifts the resulting 14-bit frame out MSB-first at a programmable bit rate. The output bit stream feeds the FSK modulator.

---
 rtl/pcm_fsk_pkg.sv | 16 +
 rtl/hamming74_enc.sv | 16 +
 rtl/pcm_hamming_tx.sv | 105 ++++++++++
 tb/tb_pcm_hamming_tx.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pcm_fsk_pkg.sv
// rtl/pcm_fsk_pkg.sv - shared state, sync-word and frame-length definitions for the PCM line coder.
// Frame length depends on FRAME_SYNC_EN.
package pcm_fsk_pkg;

  typedef enum logic [1:0] {IDLE, SYNC, HI, LO} state_t;

  localparam logic [6:0] SYNC_WORD_DEFAULT = 7'b1110010;
  localparam int         CW_BITS           = 7;

`ifdef FRAME_SYNC_EN
  localparam int FRAME_BITS = 3 * CW_BITS;
`else
  localparam int FRAME_BITS = 2 * CW_BITS;
`endif

endpackage

// File: rtl/hamming74_enc.sv
// rtl/hamming74_enc.sv - combinational Hamming(7,4) encoder.
// The codeword is produced in transmission order: p1, p2, n3, p3, n2, n1, n0.
module hamming74_enc (
  input  logic [3:0] nibble,
  output logic [6:0] codeword
);

  logic p1, p2, p3;

  assign p1 = nibble[3] ^ nibble[2] ^ nibble[0];
  assign p2 = nibble[3] ^ nibble[1] ^ nibble[0];
  assign p3 = nibble[2] ^ nibble[1] ^ nibble[0];

  assign codeword = {p1, p2, nibble[3], p3, nibble[2], nibble[1], nibble[0]};

endmodule

// File: rtl/pcm_hamming_tx.sv
// rtl/pcm_hamming_tx.sv - Hamming(7,4) line coder and serialiser for PCM words.
// Define FRAME_SYNC_EN to prefix every frame with SYNC_WORD.
module pcm_hamming_tx
  import pcm_fsk_pkg::*;
#(
  parameter int         CLK_PER_BIT = 4,
  parameter logic [6:0] SYNC_WORD   = SYNC_WORD_DEFAULT
) (
  input  logic       clkAD,
  input  logic       reset,
  input  logic       pcm_valid,
  input  logic [7:0] pcm_in,
  output logic       pcm_ready,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       frame_start,
  output logic       busy
);

  localparam int CNT_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;

  state_t                state;
  logic [CNT_W-1:0]      cyc_cnt;
  logic [2:0]            bit_cnt;
  logic [FRAME_BITS-1:0] frame_sr;
  logic [6:0]            hi_cw;
  logic [6:0]            lo_cw;
  logic                  cyc_last;
  logic                  bit_last;
  logic                  handshake;

  hamming74_enc u_enc_hi (
    .nibble   (pcm_in[7:4]),
    .codeword (hi_cw)
  );

  hamming74_enc u_enc_lo (
    .nibble   (pcm_in[3:0]),
    .codeword (lo_cw)
  );

  // With CLK_PER_BIT=1 every cycle is the last one, so cyc_cnt never leaves 0.
  assign cyc_last  = (cyc_cnt == CNT_W'(CLK_PER_BIT - 1));
  assign bit_last  = (bit_cnt == 3'd6);
  assign pcm_ready = (state == IDLE) && !reset;
  assign handshake = pcm_valid && pcm_ready;
  assign bit_out   = frame_sr[FRAME_BITS-1];

  always_ff @(posedge clkAD) begin
    if (reset) begin
      state       <= IDLE;
      cyc_cnt     <= '0;
      bit_cnt     <= '0;
      frame_sr    <= '0;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          frame_start <= 1'b0;
          if (handshake) begin
            cyc_cnt     <= '0;
            bit_cnt     <= '0;
            bit_valid   <= 1'b1;
            frame_start <= 1'b1;
            busy        <= 1'b1;
`ifdef FRAME_SYNC_EN
            frame_sr    <= {SYNC_WORD, hi_cw, lo_cw};
            state       <= SYNC;
`else
            frame_sr    <= {hi_cw, lo_cw};
            state       <= HI;
`endif
          end
        end
        default: begin
          frame_start <= 1'b0;
          if (cyc_last) begin
            cyc_cnt  <= '0;
            // Zeros shift in, so the register is empty (bit_out=0) once the frame ends.
            frame_sr <= {frame_sr[FRAME_BITS-2:0], 1'b0};
            if (bit_last) begin
              bit_cnt <= '0;
              case (state)
                SYNC:    state <= HI;
                HI:      state <= LO;
                default: begin
                  state     <= IDLE;
                  bit_valid <= 1'b0;
                  busy      <= 1'b0;
                end
              endcase
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcm_hamming_tx.sv
// tb/tb_pcm_hamming_tx.sv - directed bench for pcm_hamming_tx at CLK_PER_BIT 1, 2 and 4.
module tb_pcm_hamming_tx;

`ifdef FRAME_SYNC_EN
  localparam int NB = 21;
`else
  localparam int NB = 14;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pcm_in;
  logic [2:0] valid;
  logic [2:0] ready, bout, bval, fst, bsy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Index 0: CLK_PER_BIT=1, index 1: CLK_PER_BIT=2, index 2: CLK_PER_BIT=4.
  pcm_hamming_tx #(.CLK_PER_BIT(1)) dut1 (
    .clkAD(clk), .reset(reset), .pcm_valid(valid[0]), .pcm_in(pcm_in),
    .pcm_ready(ready[0]), .bit_out(bout[0]), .bit_valid(bval[0]),
    .frame_start(fst[0]), .busy(bsy[0])
  );

  pcm_hamming_tx #(.CLK_PER_BIT(2)) dut2 (
    .clkAD(clk), .reset(reset), .pcm_valid(valid[1]), .pcm_in(pcm_in),
    .pcm_ready(ready[1]), .bit_out(bout[1]), .bit_valid(bval[1]),
    .frame_start(fst[1]), .busy(bsy[1])
  );

  pcm_hamming_tx #(.CLK_PER_BIT(4)) dut4 (
    .clkAD(clk), .reset(reset), .pcm_valid(valid[2]), .pcm_in(pcm_in),
    .pcm_ready(ready[2]), .bit_out(bout[2]), .bit_valid(bval[2]),
    .frame_start(fst[2]), .busy(bsy[2])
  );

  typedef struct {
    logic [7:0]  word;
    bit          keep;
    logic [7:0]  next_word;
    logic [13:0] exp;
  } vec_t;

  function automatic logic [20:0] with_sync(input logic [13:0] data);
    logic [6:0] sw;
    sw = 7'b1110010;
`ifdef FRAME_SYNC_EN
    return {sw, data};
`else
    if (sw == 7'd0) return 21'd0;
    return {7'd0, data};
`endif
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic int cpb_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 2 : 4;
  endfunction

  // Entered just after a falling edge; leaves at the falling edge of the first idle cycle.
  task automatic run_frame(input string nm, input int d, input logic [7:0] w,
                           input logic [20:0] exp, input bit keep,
                           input logic [7:0] next_w, input int inject_at,
                           output int hs_wait);
    int          cpb;
    int          vcnt;
    int          fcnt;
    int          hold_bad;
    bit          ffirst;
    logic [20:0] frame;
    cpb = cpb_of(d);
    vcnt = 0; fcnt = 0; hold_bad = 0; ffirst = 0; frame = '0; hs_wait = 0;
    pcm_in   = w;
    valid[d] = 1'b1;
    while (!ready[d] && hs_wait < 50) begin
      @(negedge clk);
      hs_wait++;
    end
    check({nm, "_hs"}, 32'(ready[d]), 32'd1);
    @(negedge clk);
    if (keep) pcm_in = next_w;
    else      valid[d] = 1'b0;
    for (int c = 0; c < NB * cpb; c++) begin
      if (c % cpb == 0) frame[NB-1-c/cpb] = bout[d];
      else if (bout[d] !== frame[NB-1-c/cpb]) hold_bad++;
      if (bval[d] && bsy[d] && !ready[d]) vcnt++;
      if (fst[d]) begin
        fcnt++;
        if (c == 0) ffirst = 1'b1;
      end
      if (c == inject_at) begin
        pcm_in   = 8'h3C;
        valid[d] = 1'b1;
      end else if (inject_at >= 0 && c == inject_at + 1) begin
        valid[d] = 1'b0;
        pcm_in   = w;
      end
      @(negedge clk);
    end
    check({nm, "_frame"}, 32'(frame), 32'(exp));
    check({nm, "_hold"}, 32'(hold_bad), 32'd0);
    check({nm, "_fstart"}, {30'd0, ffirst, fcnt == 1}, 32'd3);
    check({nm, "_valid_cycles"}, 32'(vcnt), 32'(NB * cpb));
    check({nm, "_end_idle"}, {29'd0, bval[d], bsy[d], ready[d]}, 32'd1);
  endtask

  vec_t vecs[5];

  initial begin
    int hs;
    int late;
    bit prev_keep;

    vecs[0] = '{8'hA5, 1'b0, 8'h00, 14'b1011010_0100101};
    vecs[1] = '{8'h3C, 1'b0, 8'h00, 14'b1000011_0111100};
    vecs[2] = '{8'h12, 1'b0, 8'h00, 14'b1101001_0101010};
    vecs[3] = '{8'h00, 1'b1, 8'hFF, 14'b0000000_0000000};
    vecs[4] = '{8'hFF, 1'b0, 8'h00, 14'b1111111_1111111};

    reset  = 1'b1;
    valid  = 3'b000;
    pcm_in = 8'h00;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset_hold%0d", i), {17'd0, ready, bval, bout, bsy, fst}, 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("after_reset_ready", 32'(ready), 32'h7);
    check("after_reset_outs", {20'd0, bval, bout, bsy, fst}, 32'd0);

    // CLK_PER_BIT=1 table, including the back-to-back 00 -> FF pair.
    prev_keep = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run_frame($sformatf("vec%0d", i), 0, vecs[i].word, with_sync(vecs[i].exp),
                vecs[i].keep, vecs[i].next_word, -1, hs);
      if (prev_keep) check($sformatf("vec%0d_b2b_gap", i), 32'(hs), 32'd0);
      prev_keep = vecs[i].keep;
    end
    valid = 3'b000;
    @(negedge clk);

    // CLK_PER_BIT=4 A5 frame with a 3C pulse on pcm_valid mid-frame.
    run_frame("cpb4_a5", 2, 8'hA5, with_sync(14'b1011010_0100101), 1'b0, 8'h00, 20, hs);
    late = 0;
    for (int i = 0; i < 20; i++) begin
      if (bval[2] || bsy[2]) late++;
      @(negedge clk);
    end
    check("no_second_frame", 32'(late), 32'd0);

    // CLK_PER_BIT=2 frame (sync-prefixed when FRAME_SYNC_EN is defined).
    run_frame("cpb2_a5", 1, 8'hA5, with_sync(14'b1011010_0100101), 1'b0, 8'h00, -1, hs);

    // Reset arriving on bit 9 of a CLK_PER_BIT=4 frame.
    pcm_in   = 8'hA5;
    valid[2] = 1'b1;
    @(negedge clk);
    valid[2] = 1'b0;
    repeat (36) @(negedge clk);
    check("midframe_busy_before", {30'd0, bval[2], bsy[2]}, 32'd3);
    reset = 1'b1;
    #1;
    check("midframe_ready_in_reset", 32'(ready[2]), 32'd0);
    @(negedge clk);
    check("midframe_after_reset", {28'd0, bout[2], bval[2], bsy[2], fst[2]}, 32'd0);
    reset = 1'b0;
    #1;
    check("midframe_ready_after", 32'(ready[2]), 32'd1);
    run_frame("post_reset_ff", 2, 8'hFF, with_sync(14'h3FFF), 1'b0, 8'h00, -1, hs);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1);
  end

endmodule
